// File: rtl/legv8_pkg.sv
// Opcode constants, op enum and field widths shared with the LEGv8 control decoder.
// Range helpers serve the optional ENC_RANGE_CHECK_EN build of the encoder.
package legv8_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_ORR  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_ADDI = 4'd4,
        OP_SUBI = 4'd5,
        OP_MOVZ = 4'd6,
        OP_B    = 4'd7,
        OP_CBZ  = 4'd8,
        OP_LDUR = 4'd9,
        OP_STUR = 4'd10
    } op_e;

    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
    localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
    localparam logic [8:0]  OPC_MOVZ = 9'b110100101;
    localparam logic [5:0]  OPC_B    = 6'b000101;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;

    localparam int OP_W     = 4;
    localparam int REG_W    = 5;
    localparam int IMM_W    = 26;
    localparam int IMM_I_W  = 12;
    localparam int IMM_IM_W = 16;
    localparam int IMM_B_W  = 26;
    localparam int IMM_CB_W = 19;
    localparam int IMM_D_W  = 9;

    function automatic logic fits_u(logic [IMM_W-1:0] v, int w);
        return (v >> w) == '0;
    endfunction

    function automatic logic fits_s(logic [IMM_W-1:0] v, int w);
        logic signed [IMM_W-1:0] s;
        s = $signed(v) >>> (w - 1);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/legv8_instr_encoder_if.sv
// Request and instruction-memory write bundle of the LEGv8 encoder.
// master = loader/memory side, slave = encoder.
interface legv8_instr_encoder_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rn;
    logic [4:0]        req_rm;
    logic [25:0]       req_imm;
    logic [1:0]        req_hw;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ready;
    logic              err;
    logic              idle;

    modport master (
        output req_valid, req_op, req_rd, req_rn, req_rm,
        output req_imm, req_hw, imem_ready,
        input  req_ready, imem_we, imem_addr, imem_wdata,
        input  err, idle
    );

    modport slave (
        input  req_valid, req_op, req_rd, req_rn, req_rm,
        input  req_imm, req_hw, imem_ready,
        output req_ready, imem_we, imem_addr, imem_wdata,
        output err, idle
    );
endinterface

// File: rtl/legv8_encode.sv
// Combinational LEGv8 field packer; flags illegal ops.
// ENC_RANGE_CHECK_EN also rejects out-of-range immediates instead of truncating.
module legv8_encode
    import legv8_pkg::*;
(
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rn,
    input  logic [4:0]  req_rm,
    input  logic [25:0] req_imm,
    input  logic [1:0]  req_hw,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        unique case (req_op)
            OP_AND:  word = {OPC_AND, req_rm, 6'b0, req_rn, req_rd};
            OP_ORR:  word = {OPC_ORR, req_rm, 6'b0, req_rn, req_rd};
            OP_ADD:  word = {OPC_ADD, req_rm, 6'b0, req_rn, req_rd};
            OP_SUB:  word = {OPC_SUB, req_rm, 6'b0, req_rn, req_rd};
            OP_ADDI: word = {OPC_ADDI, req_imm[11:0], req_rn, req_rd};
            OP_SUBI: word = {OPC_SUBI, req_imm[11:0], req_rn, req_rd};
            OP_MOVZ: word = {OPC_MOVZ, req_hw, req_imm[15:0], req_rd};
            OP_B:    word = {OPC_B, req_imm};
            OP_CBZ:  word = {OPC_CBZ, req_imm[18:0], req_rd};
            OP_LDUR: word = {OPC_LDUR, req_imm[8:0], 2'b00, req_rn, req_rd};
            OP_STUR: word = {OPC_STUR, req_imm[8:0], 2'b00, req_rn, req_rd};
            default: illegal = 1'b1;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        unique case (req_op)
            OP_ADDI, OP_SUBI: if (!fits_u(req_imm, IMM_I_W))  illegal = 1'b1;
            OP_MOVZ:          if (!fits_u(req_imm, IMM_IM_W)) illegal = 1'b1;
            OP_CBZ:           if (!fits_s(req_imm, IMM_CB_W)) illegal = 1'b1;
            OP_LDUR, OP_STUR: if (!fits_s(req_imm, IMM_D_W))  illegal = 1'b1;
            default: ;
        endcase
`endif
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// LEGv8 encoder top: word FIFO, sequential imem address counter, err pulse.
// Build with ENC_RANGE_CHECK_EN to reject out-of-range immediates.
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic                  CLK,
    input logic                  resetl,
    legv8_instr_encoder_if.slave bus
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]       word;
    logic              illegal;
    logic [PW:0]       wptr_q, wptr_d;
    logic [PW:0]       rptr_q, rptr_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       last_q, last_d;
    logic              err_q, err_d;
    logic              empty, full;
    logic              accept, push, pop;
    logic [31:0]       head;

    legv8_encode u_enc (
        .req_op  (bus.req_op),
        .req_rd  (bus.req_rd),
        .req_rn  (bus.req_rn),
        .req_rm  (bus.req_rm),
        .req_imm (bus.req_imm),
        .req_hw  (bus.req_hw),
        .word    (word),
        .illegal (illegal)
    );

    // Extra pointer bit separates full from empty when the indices match.
    assign empty  = wptr_q == rptr_q;
    assign full   = (wptr_q[PW] != rptr_q[PW]) &&
                    (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign accept = bus.req_valid && !full;
    assign push   = accept && !illegal;
    assign pop    = !empty && bus.imem_ready;
    assign head   = mem_q[rptr_q[PW-1:0]];

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wptr_q[PW-1:0]] = word;
        wptr_d = wptr_q + {{PW{1'b0}}, push};
        rptr_d = rptr_q + {{PW{1'b0}}, pop};
        addr_d = pop ? addr_q + ADDR_W'(4) : addr_q;
        last_d = pop ? head : last_q;
        err_d  = accept && illegal;
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            wptr_q <= '0;
            rptr_q <= '0;
            addr_q <= BASE_ADDR;
            last_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            addr_q <= addr_d;
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    // Hold the last written word on the bus once drained.
    assign bus.req_ready  = !full;
    assign bus.imem_we    = !empty;
    assign bus.imem_wdata = empty ? last_q : head;
    assign bus.imem_addr  = addr_q;
    assign bus.err        = err_q;
    assign bus.idle       = empty;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Bench for legv8_instr_encoder: vector table, corner sequences, random traffic
// checked every cycle against a queue-based reference model.
module tb_legv8_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 64;

    logic CLK = 1'b0;
    logic resetl = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    always #5 CLK = ~CLK;

    legv8_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    legv8_instr_encoder #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR('0)
    ) dut (
        .CLK    (CLK),
        .resetl (resetl),
        .bus    (bus)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic void ref_enc(
        input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
        input logic [4:0] rm, input logic [25:0] imm, input logic [1:0] hw,
        output logic [31:0] w, output bit ok);
        longint r, i, si, d, n, m;
        i  = longint'(imm);
        d  = longint'(rd);
        n  = longint'(rn);
        m  = longint'(rm);
        si = (i >= (64'sd1 << 25)) ? i - (64'sd1 << 26) : i;
        ok = op <= 4'd10;
        r  = 0;
        case (op)
            4'd0: r = 'b10001010000 * (1 << 21) + m * 65536 + n * 32 + d;
            4'd1: r = 'b10101010000 * (1 << 21) + m * 65536 + n * 32 + d;
            4'd2: r = 'b10001011000 * (1 << 21) + m * 65536 + n * 32 + d;
            4'd3: r = 'b11001011000 * (1 << 21) + m * 65536 + n * 32 + d;
            4'd4: r = 'b1001000100 * (1 << 22) + (i % 4096) * 1024 + n * 32 + d;
            4'd5: r = 'b1101000100 * (1 << 22) + (i % 4096) * 1024 + n * 32 + d;
            4'd6: r = 'b110100101 * (1 << 23) + longint'(hw) * (1 << 21)
                      + (i % 65536) * 32 + d;
            4'd7: r = 'b000101 * (1 << 26) + i;
            4'd8: r = 'b10110100 * (1 << 24) + (i % (1 << 19)) * 32 + d;
            4'd9: r = 'b11111000010 * (1 << 21) + (i % 512) * 4096 + n * 32 + d;
            4'd10: r = 'b11111000000 * (1 << 21) + (i % 512) * 4096 + n * 32 + d;
            default: r = 0;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        case (op)
            4'd4, 4'd5: if (i >= 4096) ok = 0;
            4'd6:       if (i >= 65536) ok = 0;
            4'd8:       if (si < -(1 << 18) || si >= (1 << 18)) ok = 0;
            4'd9, 4'd10: if (si < -256 || si > 255) ok = 0;
            default: ;
        endcase
`endif
        w = r[31:0];
    endfunction

    logic [31:0] q[$];
    logic [63:0] m_addr = '0;
    bit          m_err = 1'b0;

    always @(posedge CLK) begin
        logic [31:0] w;
        bit ok, acc, popv;
        if (!resetl) begin
            q.delete();
            m_addr = '0;
            m_err  = 1'b0;
        end else begin
            acc  = bus.req_valid && (q.size() < DEPTH);
            popv = (q.size() != 0) && bus.imem_ready;
            ref_enc(bus.req_op, bus.req_rd, bus.req_rn, bus.req_rm,
                    bus.req_imm, bus.req_hw, w, ok);
            if (popv) begin
                void'(q.pop_front());
                m_addr = m_addr + 64'd4;
            end
            m_err = acc && !ok;
            if (acc && ok) q.push_back(w);
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("mon_we", 64'(bus.imem_we), 64'(q.size() != 0));
            check("mon_ready", 64'(bus.req_ready), 64'(q.size() < DEPTH));
            check("mon_idle", 64'(bus.idle), 64'(q.size() == 0));
            check("mon_err", 64'(bus.err), 64'(m_err));
            check("mon_addr", bus.imem_addr, m_addr);
            if (q.size() != 0) check("mon_wdata", 64'(bus.imem_wdata), 64'(q[0]));
        end
    end

    task automatic do_reset();
        @(posedge CLK) #1;
        resetl = 1'b0;
        @(posedge CLK) #1;
        @(posedge CLK) #1;
        resetl = 1'b1;
    endtask

    task automatic set_req(logic [3:0] op, logic [4:0] rd, logic [4:0] rn,
                           logic [4:0] rm, logic [25:0] imm, logic [1:0] hw);
        bus.req_op  = op;
        bus.req_rd  = rd;
        bus.req_rn  = rn;
        bus.req_rm  = rm;
        bus.req_imm = imm;
        bus.req_hw  = hw;
    endtask

    task automatic issue(logic [3:0] op, logic [4:0] rd, logic [4:0] rn,
                         logic [4:0] rm, logic [25:0] imm, logic [1:0] hw);
        @(posedge CLK) #1;
        set_req(op, rd, rn, rm, imm, hw);
        bus.req_valid = 1'b1;
        @(posedge CLK) #1;
        bus.req_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd, rn, rm;
        logic [25:0] imm;
        logic [1:0]  hw;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[11];

    initial begin
        tv[0]  = '{4'd2, 5'd3, 5'd1, 5'd2, 26'd0, 2'd0, 32'h8B020023};
        tv[1]  = '{4'd9, 5'd9, 5'd22, 5'd0, 26'd64, 2'd0, 32'hF84402C9};
        tv[2]  = '{4'd10, 5'd9, 5'd22, 5'd0, 26'd64, 2'd0, 32'hF80402C9};
        tv[3]  = '{4'd7, 5'd0, 5'd0, 5'd0, 26'd3, 2'd0, 32'h14000003};
        tv[4]  = '{4'd8, 5'd5, 5'd0, 5'd0, 26'd2, 2'd0, 32'hB4000045};
        tv[5]  = '{4'd6, 5'd1, 5'd0, 5'd0, 26'hBEEF, 2'd1, 32'hD2B7DDE1};
        tv[6]  = '{4'd3, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0, 32'hCB000000};
        tv[7]  = '{4'd1, 5'd7, 5'd8, 5'd9, 26'd0, 2'd0, 32'hAA090107};
        tv[8]  = '{4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 2'd0, 32'h8A030041};
        tv[9]  = '{4'd5, 5'd2, 5'd3, 5'd0, 26'd5, 2'd0, 32'hD1001462};
        tv[10] = '{4'd9, 5'd1, 5'd2, 5'd0, 26'h3FFFFF8, 2'd0, 32'hF85F8041};

        bus.req_valid  = 1'b0;
        bus.imem_ready = 1'b1;
        set_req(4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 2'd0);
        @(posedge CLK) #1;
        @(posedge CLK) #1;
        chk_en = 1'b1;
        resetl = 1'b1;

        check("rst_idle", 64'(bus.idle), 64'd1);
        check("rst_we", 64'(bus.imem_we), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_addr", bus.imem_addr, 64'd0);

        for (int i = 0; i < 11; i++) begin
            issue(tv[i].op, tv[i].rd, tv[i].rn, tv[i].rm, tv[i].imm, tv[i].hw);
            check($sformatf("tv%0d_we", i), 64'(bus.imem_we), 64'd1);
            check($sformatf("tv%0d_word", i), 64'(bus.imem_wdata), 64'(tv[i].exp));
            check($sformatf("tv%0d_addr", i), bus.imem_addr, 64'(4 * i));
        end

        issue(4'd15, 5'd1, 5'd1, 5'd1, 26'd0, 2'd0);
        check("ill_err", 64'(bus.err), 64'd1);
        check("ill_we", 64'(bus.imem_we), 64'd0);
        @(posedge CLK) #1;
        check("ill_err_clr", 64'(bus.err), 64'd0);

        issue(4'd4, 5'd1, 5'd0, 5'd0, 26'h1000, 2'd0);
`ifdef ENC_RANGE_CHECK_EN
        check("addi_rng_err", 64'(bus.err), 64'd1);
        check("addi_rng_we", 64'(bus.imem_we), 64'd0);
`else
        check("addi_trunc_err", 64'(bus.err), 64'd0);
        check("addi_trunc_word", 64'(bus.imem_wdata), 64'h91000001);
`endif

        do_reset();
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK) #1;
            set_req(4'd2, 5'(i), 5'd1, 5'd2, 26'd0, 2'd0);
            bus.req_valid = 1'b1;
        end
        @(posedge CLK) #1;
        bus.req_rd = 5'd4;
        check("bp_full", 64'(bus.req_ready), 64'd0);
        check("bp_head", 64'(bus.imem_wdata), 64'h8B020020);
        @(posedge CLK) #1;
        check("bp_hold", 64'(bus.req_ready), 64'd0);
        bus.imem_ready = 1'b1;
        @(posedge CLK) #1;
        check("bp_addr1", bus.imem_addr, 64'h4);
        check("bp_head1", 64'(bus.imem_wdata), 64'h8B020021);
        @(posedge CLK) #1;
        bus.req_valid = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        check("bp_idle", 64'(bus.idle), 64'd1);
        check("bp_end_addr", bus.imem_addr, 64'h14);

        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK) #1;
            set_req(4'd2, 5'(i), 5'd1, 5'd2, 26'd0, 2'd0);
            bus.req_valid = 1'b1;
        end
        @(posedge CLK) #1;
        bus.req_valid = 1'b0;
        check("mid_we", 64'(bus.imem_we), 64'd1);
        bus.imem_ready = 1'b1;
        resetl = 1'b0;
        @(posedge CLK) #1;
        resetl = 1'b1;
        check("mid_idle", 64'(bus.idle), 64'd1);
        check("mid_we0", 64'(bus.imem_we), 64'd0);
        issue(4'd2, 5'd5, 5'd1, 5'd2, 26'd0, 2'd0);
        check("mid_word", 64'(bus.imem_wdata), 64'h8B020025);
        check("mid_addr", bus.imem_addr, 64'h0);

        for (int c = 0; c < 600; c++) begin
            @(posedge CLK) #1;
            resetl = ($urandom_range(0, 199) != 0);
            bus.req_valid  = ($urandom_range(0, 3) != 0);
            bus.imem_ready = ($urandom_range(0, 2) != 0);
            set_req(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom),
                    5'($urandom), 26'($urandom), 2'($urandom));
            if ($urandom_range(0, 1) == 0) bus.req_imm = 26'($urandom_range(0, 600));
            if ($urandom_range(0, 3) == 0) bus.req_imm = 26'h3FFFFFF - 26'($urandom_range(0, 300));
        end
        @(posedge CLK) #1;
        resetl = 1'b1;
        bus.req_valid  = 1'b0;
        bus.imem_ready = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        check("final_idle", 64'(bus.idle), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/legv8_instr_encoder.md
# legv8_instr_encoder

- Converts structured LEGv8 instruction requests into 32-bit machine words.
- Encodes the opcode and field layout that the single-cycle control decoder consumes.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory through a ready/valid write port.
- Used as the program loader and assembler front-end ahead of the single-cycle processor.

## Interface
- DEPTH, 4: encoded-word FIFO entries (power of two, ≥2)
- ADDR_W, 64: instruction-memory address width
- BASE_ADDR, 0: first write address after reset
- CLK  in  1  clock; all state updates on rising edge
- resetl  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  encoder can accept; equals !full
- req_op  in  4  0 AND, 1 ORR, 2 ADD, 3 SUB, 4 ADDI, 5 SUBI, 6 MOVZ, 7 B, 8 CBZ, 9 LDUR, 10 STUR; 11–15 illegal
- req_rd  in  5  Rd; Rt for LDUR/STUR/CBZ
- req_rn  in  5  Rn
- req_rm  in  5  Rm (R-type only)
- req_imm  in  26  immediate, low bits used per format
- req_hw  in  2  MOVZ shift (LSL 16·hw)
- imem_we  out  1  write valid; high whenever FIFO non-empty
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word (FIFO head)
- imem_ready  in  1  memory accepts write
- err  out  1  one-cycle pulse: rejected request
- idle  out  1  FIFO empty

## Operation
- Accept on rising edge when req_valid && req_ready. Encode combinationally from the req_* inputs and push the word the same edge.
- Unused fields are 0.
- Formats:
  - R (AND 10001010000, ORR 10101010000, ADD 10001011000, SUB 11001011000): op[31:21], Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0].
  - I (ADDI 1001000100, SUBI 1101000100): op[31:22], imm[11:0]→[21:10], Rn, Rd.
  - IM (MOVZ 110100101): op[31:23], hw[22:21], imm[15:0]→[20:5], Rd.
  - B (000101): op[31:26], imm[25:0].
  - CB (CBZ 10110100): op[31:24], imm[18:0]→[23:5], Rt[4:0].
  - D (LDUR 11111000010, STUR 11111000000): op[31:21], imm[8:0]→[20:12], op2[11:10]=00, Rn, Rt.
- Illegal op:
  - The request is accepted (handshake completes) but not pushed.
  - err goes high for exactly the cycle after the accepting edge.
- Output write:
  - imem_we = !empty; imem_wdata = head word; imem_addr = address register.
  - A write completes on an edge where imem_we && imem_ready. That edge pops the FIFO and adds 4 to the address.
- Address wraps modulo 2^ADDR_W.
- Push and pop on the same edge: both occur, occupancy unchanged.
- Full: req_ready is low. There is no same-cycle bypass through a pop.
- Empty: imem_we is low, and imem_wdata/imem_addr hold their last value.

## Timing
- Reset (resetl low at an edge) forces: FIFO empty, address = BASE_ADDR, err = 0, imem_we = 0, req_ready = 1, idle = 1.
- Reset applied mid-stream discards all buffered words. A write in flight during the reset edge does not complete and the address does not advance.
- Latency: a request accepted at edge N appears on imem_we/imem_wdata in cycle N+1 (when the FIFO was empty).
- Sustained throughput: 1 word/cycle with imem_ready held high.
- idle is valid the cycle after the final pop.

## Configuration
- ENC_RANGE_CHECK_EN defined:
  - Immediates out of range are treated as illegal: err pulses and nothing is pushed.
  - Ranges: ADDI/SUBI unsigned 12-bit; MOVZ unsigned 16-bit; LDUR/STUR signed 9-bit; CBZ signed 19-bit. B is never checked.
- ENC_RANGE_CHECK_EN undefined: immediates are silently truncated to the field width.

## Structure
- Shared package legv8_pkg:
  - op enum values 0–10
  - all opcode constants above
  - field-width localparams
  - These are shared with the control decoder.
- Sub-module legv8_encode: purely combinational. Inputs req_op/rd/rn/rm/imm/hw; outputs word[31:0] and illegal. Holds the range check under the macro.
- Top level: FIFO, address counter, err register.

## Test plan
- ADD, rd=3, rn=1, rm=2, imem_ready=1 after reset → imem_wdata 0x8B020023 at addr 0x0, one cycle after accept.
- LDUR rd=9, rn=22, imm=64, then STUR → first word 0xF84402C9 at addr 0x0, second at 0x4.
- B imm=3 → 0x14000003. CBZ rd=5 imm=2 → 0xB4000045. MOVZ rd=1 imm=0xBEEF hw=1 → 0xD2B7DDE1.
- Backpressure: imem_ready=0, issue 5 ADDs → req_ready low after 4 accepts. Raise imem_ready → writes at 0x0, 0x4, 0x8, 0xC, then the fifth at 0x10.
- Errors:
  - req_op=15 → err high one cycle, no imem_we.
  - ADDI rd=1 rn=0 imm=0x1000: with ENC_RANGE_CHECK_EN → err, no write; without → 0x91000001.
- Reset mid-stream with 3 words buffered → idle=1, imem_we=0 after the reset edge. The next accepted word is written at BASE_ADDR.
